// File: rtl/gsim_pkg.sv
// Shared constants and FSM state type for the solver result buffer.
// Used by gsim_result_buffer and gsim_round.
package gsim_pkg;

  localparam int N_UNK  = 16;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/gsim_round.sv
// Round a signed fixed-point word to the nearest integer,
// saturating positive overflow to the largest integer value.
module gsim_round
  import gsim_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int F = FRAC_W
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  localparam logic [W-1:0] HALF = W'(1) << (F - 1);
  localparam logic [W-1:0] MASK = ~((W'(1) << F) - W'(1));
  localparam logic [W-1:0] SAT  = {1'b0, {(W-F-1){1'b1}}, {F{1'b0}}};

  logic [W-1:0] sum;
  logic         ovf;

  always_comb begin
    sum = x_i + HALF;
    // Only a non-negative input can wrap past the sign bit
    ovf = !x_i[W-1] && sum[W-1];
    y_o = ovf ? SAT : (sum & MASK);
  end

endmodule

// File: rtl/gsim_result_buffer.sv
// Captures one solver sweep into a frame buffer and drains it downstream.
// Optional capture-time rounding: define GSIM_RESULT_ROUND_EN.
module gsim_result_buffer
  import gsim_pkg::*;
#(
  parameter int N_UNK  = gsim_pkg::N_UNK,
  parameter int DATA_W = gsim_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_in,
  input  logic              x_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              out_valid,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int IDX_W = (N_UNK > 1) ? $clog2(N_UNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_UNK - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic              wr_en;
  logic              drain;
  logic              accept;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem_q [N_UNK];

`ifdef GSIM_RESULT_ROUND_EN
  gsim_round #(
    .W (DATA_W),
    .F (FRAC_W)
  ) u_round (
    .x_i (x_in),
    .y_o (wr_data)
  );
`else
  assign wr_data = x_in;
`endif

  assign drain  = (state_q == ST_DRAIN);
  assign accept = drain && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Storage is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_q] <= wr_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    wr_en        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (x_valid) begin
          wr_en    = 1'b1;
          wr_idx_d = IDX_W'(1);
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (x_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST) begin
            wr_idx_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end else begin
          wr_idx_d    = '0;
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          if (rd_idx_q == LAST) begin
            rd_idx_d     = '0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_idx_d = '0;
        rd_idx_d = '0;
      end
    endcase
  end

  always_comb begin
    out_valid  = drain;
    out_data   = drain ? mem_q[rd_idx_q] : '0;
    out_idx    = drain ? 4'(rd_idx_q) : 4'd0;
    frame_done = frame_done_q;
    frame_err  = frame_err_q;
  end

endmodule

// File: tb/tb_gsim_result_buffer.sv
// Directed bench for gsim_result_buffer: capture, drain, stall,
// short frame, reset mid-drain, DRAIN x_valid immunity, rounding.
module tb_gsim_result_buffer;
  import gsim_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] x_in;
  logic        x_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        frame_done;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;

  gsim_result_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Expected stored word for a given input
  function automatic logic [31:0] exp_word(input logic [31:0] x);
`ifdef GSIM_RESULT_ROUND_EN
    longint s;
    s = longint'($signed(x)) + 64'sd32768;
    s = s & ~longint'(65535);
    if (s > 64'sh7FFF0000) s = 64'sh7FFF0000;
    return s[31:0];
`else
    return x;
`endif
  endfunction

  task automatic drive_words(input logic [31:0] base, input int n,
                             input bit hold);
    for (int i = 0; i < n; i++) begin
      x_valid = 1'b1;
      x_in    = base + 32'(i);
      @(negedge clk);
    end
    if (!hold) begin
      x_valid = 1'b0;
      x_in    = '0;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    x_valid   = 1'b1;
    x_in      = 32'hABCD_0000;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0", out_data);
    end
    checks++;
    if (out_idx !== 4'd0) begin
      failures++;
      $display("FAIL rst_idx got=%0d exp=0", out_idx);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_done got=%b exp=0", frame_done);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_err got=%b exp=0", frame_err);
    end
    x_valid = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
    end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    drive_words(32'h0001_0000, 16, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL full_valid k=%0d got=%b exp=1", k, out_valid);
      end
      checks++;
      if (out_idx !== 4'(k)) begin
        failures++;
        $display("FAIL full_idx got=%0d exp=%0d", out_idx, k);
      end
      checks++;
      if (out_data !== exp_word(32'h0001_0000 + 32'(k))) begin
        failures++;
        $display("FAIL full_data k=%0d got=%h exp=%h", k, out_data,
                 exp_word(32'h0001_0000 + 32'(k)));
      end
      checks++;
      if (frame_done !== 1'b0) begin
        failures++;
        $display("FAIL full_early_done k=%0d got=%b exp=0", k, frame_done);
      end
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL full_done got=%b exp=1", frame_done);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_valid_drop got=%b exp=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      failures++;
      $display("FAIL full_done_pulse got=%b exp=0", frame_done);
    end
  endtask

  task automatic test_short_frame();
    drive_words(32'h0005_0000, 9, 1'b0);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL short_err_early got=%b exp=0", frame_err);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL short_err got=%b exp=1", frame_err);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      failures++;
      $display("FAIL short_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL short_err_pulse got=%b exp=0", frame_err);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_valid2 got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    int exp_idx;
    pat     = 4'b1001;
    exp_idx = 0;
    out_ready = 1'b1;
    drive_words(32'h0002_0000, 16, 1'b0);
    for (int c = 0; c < 80 && exp_idx < 16; c++) begin
      out_ready = pat[c % 4];
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_valid c=%0d got=%b exp=1", c, out_valid);
      end
      checks++;
      if (out_idx !== 4'(exp_idx)) begin
        failures++;
        $display("FAIL stall_idx c=%0d got=%0d exp=%0d", c, out_idx, exp_idx);
      end
      checks++;
      if (out_data !== exp_word(32'h0002_0000 + 32'(exp_idx))) begin
        failures++;
        $display("FAIL stall_data c=%0d got=%h exp=%h", c, out_data,
                 exp_word(32'h0002_0000 + 32'(exp_idx)));
      end
      @(negedge clk);
      if (out_ready) exp_idx++;
    end
    checks++;
    if (exp_idx != 16) begin
      failures++;
      $display("FAIL stall_timeout got=%0d exp=16", exp_idx);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL stall_done got=%b exp=1", frame_done);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 1'b1;
    drive_words(32'h0003_0000, 16, 1'b0);
    for (int k = 0; k < 7; k++) @(negedge clk);
    checks++;
    if (out_idx !== 4'd7) begin
      failures++;
      $display("FAIL rmd_idx7 got=%0d exp=7", out_idx);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmd_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++;
      $display("FAIL rmd_data got=%h exp=0", out_data);
    end
    checks++;
    if (out_idx !== 4'd0) begin
      failures++;
      $display("FAIL rmd_idx got=%0d exp=0", out_idx);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
        failures++;
        $display("FAIL rmd_pulse c=%0d got=%b%b exp=00", c, frame_done,
                 frame_err);
      end
      @(negedge clk);
    end
    drive_words(32'h0004_0000, 16, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (out_idx !== 4'(k) ||
          out_data !== exp_word(32'h0004_0000 + 32'(k))) begin
        failures++;
        $display("FAIL rmd_refill k=%0d got=%0d/%h exp=%0d/%h", k, out_idx,
                 out_data, k, exp_word(32'h0004_0000 + 32'(k)));
      end
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL rmd_done got=%b exp=1", frame_done);
    end
  endtask

  task automatic test_drain_ignore();
    out_ready = 1'b1;
    drive_words(32'h0006_0000, 16, 1'b1);
    x_in = 32'hDEAD_0000;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (out_data !== exp_word(32'h0006_0000 + 32'(k))) begin
        failures++;
        $display("FAIL ign_data k=%0d got=%h exp=%h", k, out_data,
                 exp_word(32'h0006_0000 + 32'(k)));
      end
      checks++;
      if (frame_err !== 1'b0) begin
        failures++;
        $display("FAIL ign_err k=%0d got=%b exp=0", k, frame_err);
      end
      @(negedge clk);
    end
    x_valid = 1'b0;
    x_in    = '0;
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL ign_done got=%b exp=1", frame_done);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL ign_err_after got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_words(32'h0007_0000, 16, 1'b0);
    repeat (16) @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done_a got=%b exp=1", frame_done);
    end
    drive_words(32'h0008_0000, 16, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 4'(k) ||
          out_data !== exp_word(32'h0008_0000 + 32'(k))) begin
        failures++;
        $display("FAIL b2b_word k=%0d got=%b/%0d/%h exp=1/%0d/%h", k,
                 out_valid, out_idx, out_data, k,
                 exp_word(32'h0008_0000 + 32'(k)));
      end
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done_b got=%b exp=1", frame_done);
    end
    @(negedge clk);
  endtask

`ifdef GSIM_RESULT_ROUND_EN
  task automatic test_round();
    logic [31:0] vin [3];
    logic [31:0] vexp [3];
    vin[0] = 32'h0002_8000; vexp[0] = 32'h0003_0000;
    vin[1] = 32'hFFFF_7FFF; vexp[1] = 32'hFFFF_0000;
    vin[2] = 32'h7FFF_9000; vexp[2] = 32'h7FFF_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x_valid = 1'b1;
      x_in    = (i < 3) ? vin[i] : 32'h0;
      @(negedge clk);
    end
    x_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (out_data !== ((k < 3) ? vexp[k] : 32'h0)) begin
        failures++;
        $display("FAIL round k=%0d got=%h exp=%h", k, out_data,
                 (k < 3) ? vexp[k] : 32'h0);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    reset     = 1'b1;
    x_valid   = 1'b0;
    x_in      = '0;
    out_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_stall();
    test_reset_mid_drain();
    test_drain_ignore();
    test_back_to_back();
`ifdef GSIM_RESULT_ROUND_EN
    test_round();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gsim_result_buffer.md
GSIM_RESULT_BUFFER -- requirements
Module: gsim_result_buffer

Interface
REQ-001 SHALL have parameter N_UNK, default 16, meaning the number of solution words per frame.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the solution word width in signed Q16.16.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port x_in, input, DATA_W bits; the solver solution word.
REQ-006 SHALL have port x_valid, input, 1 bit; high while the solver presents its final sweep, one word per cycle.
REQ-007 SHALL have port out_ready, input, 1 bit; the downstream accept signal.
REQ-008 SHALL have port out_data, output, DATA_W bits; the buffered solution word.
REQ-009 SHALL have port out_idx, output, 4 bits; the unknown index of out_data.
REQ-010 SHALL have port out_valid, output, 1 bit; high when out_data/out_idx are valid.
REQ-011 SHALL have port frame_done, output, 1 bit; a one-cycle pulse after the last word is accepted.
REQ-012 SHALL have port frame_err, output, 1 bit; a one-cycle pulse when a short frame is discarded.

Function
REQ-013 SHALL implement states IDLE, CAPTURE and DRAIN.
REQ-014 SHALL, in IDLE with x_valid=1, write x_in to mem[0], set wr_idx=1 and enter CAPTURE.
REQ-015 SHALL, in CAPTURE with x_valid=1, write x_in to mem[wr_idx] and increment wr_idx.
REQ-016 SHALL, on the N_UNK-th write, enter DRAIN and clear wr_idx.
REQ-017 SHALL, if x_valid=0 in CAPTURE before N_UNK writes, discard the frame, pulse frame_err the next cycle and return to IDLE.
REQ-018 SHALL, in DRAIN, drive out_valid=1, out_data=mem[rd_idx] and out_idx=rd_idx; the first word is valid the cycle after the last capture.
REQ-019 SHALL advance rd_idx on out_valid&&out_ready; out_data/out_idx SHALL hold stable while out_ready=0.
REQ-020 SHALL, on acceptance at rd_idx=N_UNK-1, clear rd_idx, drop out_valid, pulse frame_done the next cycle and enter IDLE.
REQ-021 SHALL ignore x_valid in DRAIN (no write, no error).
REQ-022 SHALL sustain a throughput of one word per cycle with out_ready held high; a full frame drains in N_UNK cycles.
REQ-023 SHALL accept a new frame in the cycle directly after DRAIN exits.

Reset
REQ-024 SHALL, when reset=1, take state=IDLE, wr_idx=0, rd_idx=0, out_valid=0, out_data=0, out_idx=0, frame_done=0 and frame_err=0, regardless of state.
REQ-025 SHALL discard a frame interrupted mid-CAPTURE or mid-DRAIN by reset and produce no pulse.
REQ-026 SHALL NOT reset the storage mem contents.

Configuration
REQ-027 SHALL, with macro GSIM_RESULT_ROUND_EN defined, round each word to an integer at capture: add 0x0000_8000, clear bits [15:0], and saturate positive overflow to 0x7FFF_0000.
REQ-028 SHALL, with GSIM_RESULT_ROUND_EN undefined, store and emit x_in unmodified.

Structure
REQ-029 SHALL place N_UNK, DATA_W, FRAC_W (16) and the state enum in the shared package gsim_pkg.
REQ-030 SHALL implement rounding in a single combinational sub-module gsim_round, instantiated only under GSIM_RESULT_ROUND_EN.

Verification
REQ-031 SHALL verify: 16 cycles of x_valid with x_in=0x0001_0000+k, out_ready=1 -> out_idx 0..15 with the matching data, then frame_done pulses once.
REQ-032 SHALL verify: x_valid for 9 cycles then low -> frame_err pulse, out_valid stays 0, state returns to IDLE.
REQ-033 SHALL verify: out_ready toggling 1,0,0,1 during DRAIN -> out_data/out_idx stable while stalled, no word lost or duplicated.
REQ-034 SHALL verify: reset asserted at drain index 7 -> all outputs 0 next cycle; a following 16-word frame drains correctly from index 0.
REQ-035 SHALL verify, with GSIM_RESULT_ROUND_EN: x_in=0x0002_8000 -> 0x0003_0000; 0xFFFF_7FFF -> 0xFFFF_0000; 0x7FFF_9000 -> 0x7FFF_0000.
REQ-036 SHALL verify: x_valid held high during DRAIN -> stored data unchanged and no frame_err.
